platform_scheduler: RTL and testbench
=====================================

# platform_scheduler

Owns the 16 platform slot positions for the playfield and sequences their per-frame update. After reset it fills every slot from an external random source. On each frame tick it scrolls all slots down by a requested amount. Any slot that falls off the bottom is respawned at the top with a fresh random X. It sits between the game-physics logic, which supplies the scroll amount, and the color mapper / collision logic, which read the flattened position buses.

## Interface
Parameters:
- NUM_PLAT, 16: number of platform slots (fixed 4-bit index; max 16)
- SCREEN_H, 480: visible lines
- PLAT_SIZE, 4: platform half-size in pixels
- SPACING, 30: initial vertical pitch between slots
- X_OFFSET, 64: added to the random value to form X

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- frame_clk  in  1  per-frame strobe from VGA timing; asynchronous to Clk, treated as level
- scroll_amt  in  5  pixels to scroll this frame, sampled on the accepted tick
- rnd_req  out  1  request for one random value
- rnd_valid  in  1  random value available
- rnd_data  in  9  random value, consumed in the cycle where rnd_req && rnd_valid
- plat_x  out  10*NUM_PLAT  slot i X at bits [10i+9:10i]
- plat_y  out  10*NUM_PLAT  slot i Y at bits [10i+9:10i]
- busy  out  1  high whenever state != IDLE
- init_done  out  1  sticky; set when the initial fill completes
- frame_done  out  1  one-cycle pulse at the end of each frame update
- respawn  out  1  one-cycle pulse per respawned slot
- respawn_cnt  out  16  respawns since reset, wraps at 16'hFFFF→0
- overrun  out  1  sticky; a tick arrived while not in IDLE (excluding INIT)

## Operation
- Tick detection: frame_clk passes through a 2-flop synchronizer and a rising-edge detector, giving a 1-cycle `tick`. Synchronizer flops reset to 0.
- States: INIT, IDLE, SCROLL, RESPAWN, DONE. A 4-bit slot index `idx` is used throughout.
- rnd_req = (state==INIT || state==RESPAWN) && !Reset.
- INIT (entered at reset, idx=0):
  - On each rnd_req && rnd_valid: slot idx X = rnd_data + X_OFFSET; Y = min(SPACING*(idx+1), SCREEN_H-1-PLAT_SIZE).
  - After slot NUM_PLAT-1 is written: set init_done and go to IDLE.
  - Ticks during INIT are ignored and do not set overrun.
- IDLE: on a tick, latch amt = scroll_amt and set idx=0.
  - If amt==0: go to DONE.
  - Otherwise: go to SCROLL.
- SCROLL: compute s = Y[idx] + amt in 11 bits.
  - If s >= SCREEN_H + PLAT_SIZE: hold wy = s - SCREEN_H and go to RESPAWN.
  - Otherwise: write Y[idx] = s[9:0].
  - If idx was the last slot, go to DONE; else idx++.
- RESPAWN: wait for rnd_valid, then in that cycle write X[idx] = rnd_data + X_OFFSET and Y[idx] = wy. Pulse respawn and increment respawn_cnt (both registered, visible the next cycle). Then go back to SCROLL with idx+1, or to DONE if it was the last slot.
- DONE: pulse frame_done and return to IDLE.
- A tick in SCROLL/RESPAWN/DONE is dropped and sets overrun. The update in progress continues unaffected.
- Width rules: X sum is 10 bits, maximum 511+64=575. Y stays below 484 by construction.

## Timing
- Reset values: plat_x=0, plat_y=0, init_done=0, frame_done=0, respawn=0, respawn_cnt=0, overrun=0, idx=0, state=INIT. busy=1 and rnd_req=0 while Reset is high.
- Reset asserted mid-operation: all state is discarded and the next cycle restarts INIT.
- Tick latency: a frame_clk rise produces a tick 3 Clk cycles later.
- INIT with rnd_valid held high: one slot per cycle, so init_done rises 17 cycles after Reset is released.
- Frame update with rnd_valid held high:
  - Each non-wrapping slot takes 1 cycle; each wrapping slot takes 2.
  - Total = NUM_PLAT + (wraps) + 1 (DONE) cycles from the first SCROLL cycle.
  - With amt==0: frame_done pulses 2 cycles after the tick.
- If rnd_valid is low, RESPAWN or INIT holds with rnd_req high, and plat_x/plat_y for that slot are unchanged.
- Position writes become visible on the cycle after the write state.

## Test plan
- Reset, rnd_valid=1, rnd_data=9'd100 constant → all X=164; Y = 30,60,...,450 and slot15 = 475; init_done at cycle 17; rnd_req low during Reset.
- After init, tick with scroll_amt=10 → slot14 Y=460; slot15 475+10=485 wraps to Y=5 with new X; exactly one respawn pulse; respawn_cnt=1; frame_done 18 cycles after entering SCROLL.
- Tick with scroll_amt=0 → no position change; frame_done pulses 2 cycles after the tick.
- rnd_valid low for 5 cycles during a RESPAWN → rnd_req stays high, the slot is unchanged until valid, and frame_done is delayed by 5 cycles.
- Second frame_clk rise while busy → overrun=1 (sticky), no extra frame_done, positions match single-update reference.
- Reset asserted in the middle of SCROLL → outputs return to reset values and INIT re-runs; init_done is 0 until the fill completes.

Source files
------------

// File: rtl/platform_scheduler_if.sv
// ---------------------------------------------------------------------------
// platform_scheduler_if
//   Request/valid handshake between the platform scheduler and the random
//   number source that supplies fresh X coordinates.
//
//   rnd_req    scheduler -> source : one random value is wanted this cycle
//   rnd_valid  source -> scheduler : rnd_data holds a usable value
//   rnd_data   source -> scheduler : 9-bit random value, consumed in any
//                                    cycle where rnd_req && rnd_valid
//
//   master : the scheduler (drives rnd_req)
//   slave  : the random source (drives rnd_valid / rnd_data)
// ---------------------------------------------------------------------------
interface platform_scheduler_if;
    logic       rnd_req;
    logic       rnd_valid;
    logic [8:0] rnd_data;

    modport master (output rnd_req, input rnd_valid, input rnd_data);
    modport slave  (input rnd_req, output rnd_valid, output rnd_data);
endinterface

// File: rtl/platform_scheduler.sv
// ---------------------------------------------------------------------------
// platform_scheduler
//   Owns the NUM_PLAT platform slot positions. After reset every slot is
//   filled from the random source (X) with a fixed vertical pitch (Y). On
//   each frame tick all slots scroll down by scroll_amt; a slot that falls
//   off the bottom is respawned near the top with a fresh random X.
//
//   Clk          system clock
//   Reset        synchronous, active-high reset
//   frame_clk    per-frame strobe, asynchronous to Clk (synchronised here)
//   scroll_amt   pixels to scroll, sampled when the tick is accepted
//   rnd          random-source handshake (master side)
//   plat_x/y     flattened positions, slot i at bits [10i+9:10i]
//   busy         high whenever the scheduler is not idle (and during Reset)
//   init_done    sticky, set once the initial fill completes
//   frame_done   one-cycle pulse at the end of each frame update
//   respawn      one-cycle pulse per respawned slot
//   respawn_cnt  respawns since reset, wrapping
//   overrun      sticky, a tick arrived while an update was in progress
// ---------------------------------------------------------------------------
module platform_scheduler #(
    parameter int unsigned NUM_PLAT  = 16,
    parameter int unsigned SCREEN_H  = 480,
    parameter int unsigned PLAT_SIZE = 4,
    parameter int unsigned SPACING   = 30,
    parameter int unsigned X_OFFSET  = 64
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     frame_clk,
    input  logic [4:0]               scroll_amt,
    platform_scheduler_if.master     rnd,
    output logic [10*NUM_PLAT-1:0]   plat_x,
    output logic [10*NUM_PLAT-1:0]   plat_y,
    output logic                     busy,
    output logic                     init_done,
    output logic                     frame_done,
    output logic                     respawn,
    output logic [15:0]              respawn_cnt,
    output logic                     overrun
);

    localparam logic [3:0]  LAST_IDX = 4'(NUM_PLAT - 1);
    localparam int unsigned Y_MAX    = SCREEN_H - 1 - PLAT_SIZE;
    localparam logic [10:0] WRAP_AT  = 11'(SCREEN_H + PLAT_SIZE);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_SCROLL,
        S_RESPAWN,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [4:0]  amt_q, amt_d;
    logic [9:0]  wy_q, wy_d;
    logic [9:0]  x_q [NUM_PLAT];
    logic [9:0]  y_q [NUM_PLAT];

    logic        sync1_q, sync2_q, sync3_q, tick_q;

    logic        init_done_q, init_done_d;
    logic        frame_done_q, frame_done_d;
    logic        respawn_q, respawn_d;
    logic [15:0] respawn_cnt_q, respawn_cnt_d;
    logic        overrun_q, overrun_d;

    logic        wr_en, wr_x_en;
    logic [9:0]  wr_y;
    logic [9:0]  rnd_x;
    logic [9:0]  init_y;
    logic [10:0] scroll_sum;

    // Values derived from the current slot / random input.
    always_comb begin
        int unsigned y_lin;
        rnd_x      = 10'(rnd.rnd_data) + 10'(X_OFFSET);
        y_lin      = SPACING * (32'(idx_q) + 32'd1);
        init_y     = (y_lin > Y_MAX) ? 10'(Y_MAX) : 10'(y_lin);
        scroll_sum = 11'(y_q[idx_q]) + 11'(amt_q);
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        amt_d         = amt_q;
        wy_d          = wy_q;
        wr_en         = 1'b0;
        wr_x_en       = 1'b0;
        wr_y          = scroll_sum[9:0];
        init_done_d   = init_done_q;
        frame_done_d  = 1'b0;
        respawn_d     = 1'b0;
        respawn_cnt_d = respawn_cnt_q;
        overrun_d     = overrun_q;

        // Ticks are only acted on in IDLE; INIT drops them silently.
        if (tick_q && (state_q == S_SCROLL || state_q == S_RESPAWN ||
                       state_q == S_DONE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_INIT: begin
                if (rnd.rnd_valid) begin
                    wr_en   = 1'b1;
                    wr_x_en = 1'b1;
                    wr_y    = init_y;
                    if (idx_q == LAST_IDX) begin
                        init_done_d = 1'b1;
                        idx_d       = '0;
                        state_d     = S_IDLE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            S_IDLE: begin
                if (tick_q) begin
                    amt_d   = scroll_amt;
                    idx_d   = '0;
                    state_d = (scroll_amt == 5'd0) ? S_DONE : S_SCROLL;
                end
            end
            S_SCROLL: begin
                if (scroll_sum >= WRAP_AT) begin
                    // Slot left the screen: keep the wrapped Y until a
                    // random X is available, idx stays on this slot.
                    wy_d    = 10'(scroll_sum - 11'(SCREEN_H));
                    state_d = S_RESPAWN;
                end else begin
                    wr_en = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            S_RESPAWN: begin
                if (rnd.rnd_valid) begin
                    wr_en         = 1'b1;
                    wr_x_en       = 1'b1;
                    wr_y          = wy_q;
                    respawn_d     = 1'b1;
                    respawn_cnt_d = respawn_cnt_q + 16'd1;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_SCROLL;
                    end
                end
            end
            S_DONE: begin
                frame_done_d = 1'b1;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= S_INIT;
            idx_q         <= '0;
            amt_q         <= '0;
            wy_q          <= '0;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            sync3_q       <= 1'b0;
            tick_q        <= 1'b0;
            init_done_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            respawn_q     <= 1'b0;
            respawn_cnt_q <= '0;
            overrun_q     <= 1'b0;
            for (int unsigned i = 0; i < NUM_PLAT; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            amt_q         <= amt_d;
            wy_q          <= wy_d;
            sync1_q       <= frame_clk;
            sync2_q       <= sync1_q;
            sync3_q       <= sync2_q;
            tick_q        <= sync2_q & ~sync3_q;
            init_done_q   <= init_done_d;
            frame_done_q  <= frame_done_d;
            respawn_q     <= respawn_d;
            respawn_cnt_q <= respawn_cnt_d;
            overrun_q     <= overrun_d;
            if (wr_en) begin
                y_q[idx_q] <= wr_y;
            end
            if (wr_x_en) begin
                x_q[idx_q] <= rnd_x;
            end
        end
    end

    always_comb begin
        plat_x = '0;
        plat_y = '0;
        for (int unsigned i = 0; i < NUM_PLAT; i++) begin
            plat_x[10*i +: 10] = x_q[i];
            plat_y[10*i +: 10] = y_q[i];
        end
    end

    assign rnd.rnd_req = !Reset && (state_q == S_INIT || state_q == S_RESPAWN);
    assign busy        = Reset || (state_q != S_IDLE);
    assign init_done   = init_done_q;
    assign frame_done  = frame_done_q;
    assign respawn     = respawn_q;
    assign respawn_cnt = respawn_cnt_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_platform_scheduler.sv
// ---------------------------------------------------------------------------
// tb_platform_scheduler
//   Randomised bench for platform_scheduler. A reference model holds the 16
//   slot positions as plain integers, fills them from the random values the
//   DUT actually consumed, and applies each frame's scroll/wrap rule with
//   ordinary arithmetic.
// ---------------------------------------------------------------------------
module tb_platform_scheduler;

    localparam int NP = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_clk;
    logic [4:0]    scroll_amt;
    logic [10*NP-1:0] plat_x, plat_y;
    logic          busy, init_done, frame_done, respawn, overrun;
    logic [15:0]   respawn_cnt;

    platform_scheduler_if rnd_bus ();

    platform_scheduler #(
        .NUM_PLAT  (NP),
        .SCREEN_H  (480),
        .PLAT_SIZE (4),
        .SPACING   (30),
        .X_OFFSET  (64)
    ) dut (
        .Clk         (clk),
        .Reset       (rst),
        .frame_clk   (frame_clk),
        .scroll_amt  (scroll_amt),
        .rnd         (rnd_bus),
        .plat_x      (plat_x),
        .plat_y      (plat_y),
        .busy        (busy),
        .init_done   (init_done),
        .frame_done  (frame_done),
        .respawn     (respawn),
        .respawn_cnt (respawn_cnt),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    int mx [NP];
    int my [NP];
    int rsp_total = 0;
    bit exp_ovr   = 1'b0;

    // Observed traffic.
    logic [8:0] consumed [$];
    int fd_cnt  = 0;
    int rsp_cnt = 0;

    bit rand_data  = 1'b0;
    bit rand_valid = 1'b0;

    always @(posedge clk) begin
        if (rnd_bus.rnd_req && rnd_bus.rnd_valid) consumed.push_back(rnd_bus.rnd_data);
        if (frame_done) fd_cnt++;
        if (respawn) rsp_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_data) rnd_bus.rnd_data = 9'($urandom);
        if (rand_valid) rnd_bus.rnd_valid = ($urandom_range(0, 3) != 0);
    endtask

    function automatic int get_x(int i);
        return int'(plat_x[10*i +: 10]);
    endfunction

    function automatic int get_y(int i);
        return int'(plat_y[10*i +: 10]);
    endfunction

    function automatic int next_rnd();
        if (consumed.size() == 0) return 0;
        return int'(consumed.pop_front());
    endfunction

    // Initial fill: slot i gets the i-th consumed value, Y on a 30-line
    // pitch clamped to the last legal line 475.
    task automatic model_init();
        check_eq("init_consumed", consumed.size(), NP);
        for (int i = 0; i < NP; i++) begin
            mx[i] = next_rnd() + 64;
            my[i] = (30 * (i + 1) > 475) ? 475 : 30 * (i + 1);
        end
    endtask

    // One frame: every slot moves down by amt; a slot reaching line 484
    // reappears 480 lines higher with the next consumed random X.
    task automatic model_frame(input int amt, output int wraps);
        wraps = 0;
        for (int i = 0; i < NP; i++) begin
            int ny;
            ny = my[i] + amt;
            if (ny >= 484) begin
                my[i] = ny - 480;
                mx[i] = next_rnd() + 64;
                wraps++;
            end else begin
                my[i] = ny;
            end
        end
    endtask

    task automatic check_slots(input string tag);
        for (int i = 0; i < NP; i++) begin
            check_eq($sformatf("%s_x%0d", tag, i), get_x(i), mx[i]);
            check_eq($sformatf("%s_y%0d", tag, i), get_y(i), my[i]);
        end
    endtask

    task automatic wait_init(output int n);
        n = 0;
        for (int k = 0; k < 100 && !init_done; k++) begin
            step();
            n++;
        end
        check_eq("init_done_seen", init_done, 1);
    endtask

    // Latency is counted in clock edges from the cycle frame_clk rises to
    // the first sample showing frame_done: 3 to the tick, 1 to leave IDLE,
    // then one per slot, one extra per wrap, one for DONE.
    task automatic post_frame_checks(input string tag, input int amt, input int edges,
                                     input bit lat_on, input int extra);
        int w;
        model_frame(amt, w);
        rsp_total += w;
        check_slots(tag);
        check_eq({tag, "_leftover_rnd"}, consumed.size(), 0);
        check_eq({tag, "_rsp_pulses"}, rsp_cnt, w);
        check_eq({tag, "_fd_pulses"}, fd_cnt, 1);
        check_eq({tag, "_rsp_cnt"}, respawn_cnt, rsp_total & 16'hFFFF);
        check_eq({tag, "_overrun"}, overrun, exp_ovr);
        check_eq({tag, "_busy"}, busy, 0);
        if (lat_on)
            check_eq({tag, "_latency"}, edges, (amt == 0) ? 5 : 4 + NP + w + 1 + extra);
    endtask

    task automatic run_frame(input string tag, input int amt, input bit lat_on);
        int e;
        bit seen;
        fd_cnt     = 0;
        rsp_cnt    = 0;
        scroll_amt = 5'(amt);
        frame_clk  = 1'b1;
        e          = 0;
        seen       = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            step();
            e++;
            if (frame_done) seen = 1'b1;
        end
        check_eq({tag, "_fd_seen"}, seen, 1);
        frame_clk = 1'b0;
        repeat (3) step();
        post_frame_checks(tag, amt, e, lat_on, 0);
    endtask

    initial begin
        int n;
        int e;
        int amt;
        int held;
        bit seen;

        rst                = 1'b1;
        frame_clk          = 1'b0;
        scroll_amt         = '0;
        rnd_bus.rnd_valid  = 1'b1;
        rnd_bus.rnd_data   = 9'd100;
        repeat (3) step();

        // Reset values.
        check_eq("rst_x", |plat_x, 0);
        check_eq("rst_y", |plat_y, 0);
        check_eq("rst_busy", busy, 1);
        check_eq("rst_rnd_req", rnd_bus.rnd_req, 0);
        check_eq("rst_init_done", init_done, 0);
        check_eq("rst_frame_done", frame_done, 0);
        check_eq("rst_respawn", respawn, 0);
        check_eq("rst_rsp_cnt", respawn_cnt, 0);
        check_eq("rst_overrun", overrun, 0);

        // Initial fill with a constant 100: X = 164 everywhere. init_done
        // is first high in the 17th cycle after release (16 edges).
        consumed.delete();
        rst = 1'b0;
        wait_init(n);
        check_eq("init_latency", n, 16);
        model_init();
        check_slots("init");
        check_eq("init_x0_abs", get_x(0), 164);
        check_eq("init_y15_abs", get_y(15), 475);
        check_eq("init_busy", busy, 0);

        // Scroll by 10: only slot 15 (475 -> 485) wraps to Y=5.
        rand_data = 1'b1;
        run_frame("f10", 10, 1'b1);
        check_eq("f10_y14_abs", get_y(14), 460);
        check_eq("f10_y15_abs", get_y(15), 5);
        check_eq("f10_rsp_cnt_abs", respawn_cnt, 1);

        // Zero scroll: nothing moves, frame_done 2 cycles after the tick.
        run_frame("f0", 0, 1'b1);

        // Scroll by 24 makes slot 14 (460) wrap; hold rnd_valid low for the
        // first 5 RESPAWN cycles.
        fd_cnt            = 0;
        rsp_cnt           = 0;
        rnd_bus.rnd_valid = 1'b0;
        scroll_amt        = 5'd24;
        frame_clk         = 1'b1;
        e                 = 0;
        held              = 0;
        seen              = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            step();
            e++;
            if (held > 0 && held < 5) begin
                check_eq("hold_rnd_req", rnd_bus.rnd_req, 1);
                check_eq("hold_y14", get_y(14), 460);
                check_eq("hold_x14", get_x(14), mx[14]);
                held++;
            end else if (held == 0 && rnd_bus.rnd_req) begin
                check_eq("hold_y14_entry", get_y(14), 460);
                held = 1;
            end else if (held == 5) begin
                rnd_bus.rnd_valid = 1'b1;
                held = 6;
            end
            if (frame_done) seen = 1'b1;
        end
        check_eq("hold_fd_seen", seen, 1);
        check_eq("hold_reached", held, 6);
        frame_clk = 1'b0;
        repeat (3) step();
        post_frame_checks("hold", 24, e, 1'b1, 5);
        check_eq("hold_y14_abs", get_y(14), 4);

        // A second frame_clk rise while the update is running.
        fd_cnt     = 0;
        rsp_cnt    = 0;
        amt        = $urandom_range(1, 31);
        scroll_amt = 5'(amt);
        frame_clk  = 1'b1;
        e          = 0;
        seen       = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            step();
            e++;
            if (e == 8) frame_clk = 1'b0;
            if (e == 12) frame_clk = 1'b1;
            if (frame_done) seen = 1'b1;
        end
        check_eq("ovr_fd_seen", seen, 1);
        frame_clk = 1'b0;
        repeat (30) step();
        exp_ovr = 1'b1;
        post_frame_checks("ovr", amt, e, 1'b1, 0);

        // Random scroll amounts; odd frames also randomise rnd_valid.
        for (int f = 0; f < 8; f++) begin
            rand_valid = f[0];
            if (!rand_valid) rnd_bus.rnd_valid = 1'b1;
            run_frame($sformatf("rf%0d", f), $urandom_range(0, 31), !rand_valid);
        end
        rand_valid        = 1'b0;
        rnd_bus.rnd_valid = 1'b1;

        // Reset in the middle of SCROLL, then a fresh fill.
        scroll_amt = 5'd31;
        frame_clk  = 1'b1;
        repeat (6) step();
        check_eq("mid_busy", busy, 1);
        rst = 1'b1;
        step();
        check_eq("mid_rst_x", |plat_x, 0);
        check_eq("mid_rst_y", |plat_y, 0);
        check_eq("mid_rst_init_done", init_done, 0);
        check_eq("mid_rst_rsp_cnt", respawn_cnt, 0);
        check_eq("mid_rst_overrun", overrun, 0);
        check_eq("mid_rst_rnd_req", rnd_bus.rnd_req, 0);
        check_eq("mid_rst_busy", busy, 1);
        frame_clk = 1'b0;
        step();
        consumed.delete();
        rsp_total = 0;
        exp_ovr   = 1'b0;
        rst       = 1'b0;
        wait_init(n);
        check_eq("reinit_latency", n, 16);
        model_init();
        check_slots("reinit");
        run_frame("post", $urandom_range(1, 31), 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
